register_file: RTL and testbench

Eight-entry, 16-bit general-purpose register file for the pipelined processor's decode/write-back boundary. It is the direct consumer of the 3-to-8 write-select decode: each write port's enable and 3-bit address are expanded into a one-hot register-load vector. It holds the architectural registers R0–R7. It provides two read ports for the decode stage, with same-cycle write-to-read forwarding, and two write ports for write-back; the second write port serves SWAP-class instructions.

---
 rtl/register_file_pkg.sv | 7 +
 rtl/register_file_decoder_3x8.sv | 10 +
 rtl/register_file.sv | 49 ++++
 tb/tb_register_file.sv | 109 ++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// register_file_pkg: shared sizing constants and register index type for the register file
package register_file_pkg;
  localparam int REG_COUNT = 8;
  localparam int REG_ADDR_W = 3;
  localparam int DATA_W = 16;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/register_file_decoder_3x8.sv
// decoder_3x8: expands an enable and 3-bit index into a one-hot register-load vector
module decoder_3x8
  import register_file_pkg::*;
(
  input  logic                 EN,
  input  reg_addr_t            S,
  output logic [REG_COUNT-1:0] Dout
);
  always_comb Dout = EN ? ({{(REG_COUNT-1){1'b0}}, 1'b1} << S) : '0;
endmodule

// File: rtl/register_file.sv
// register_file: 8x16 register file, two forwarding read ports, two write ports with port B winning collisions
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_W = register_file_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_a,
  input  reg_addr_t         wr_addr_a,
  input  logic [DATA_W-1:0] wr_data_a,
  input  logic              wr_en_b,
  input  reg_addr_t         wr_addr_b,
  input  logic [DATA_W-1:0] wr_data_b,
  input  reg_addr_t         rd_addr_0,
  input  reg_addr_t         rd_addr_1,
  output logic [DATA_W-1:0] rd_data_0,
  output logic [DATA_W-1:0] rd_data_1,
  output logic              wr_conflict
);
  logic [REG_COUNT-1:0] load_a, load_b;
  logic [DATA_W-1:0] regs_q [REG_COUNT];
  logic [DATA_W-1:0] regs_d [REG_COUNT];
  logic conflict_q, conflict_d;
  decoder_3x8 u_dec_a (.EN(wr_en_a), .S(wr_addr_a), .Dout(load_a));
  decoder_3x8 u_dec_b (.EN(wr_en_b), .S(wr_addr_b), .Dout(load_b));
  always_comb begin
    for (int i = 0; i < REG_COUNT; i++)
      regs_d[i] = load_b[i] ? wr_data_b : load_a[i] ? wr_data_a : regs_q[i];
    conflict_d = wr_en_a & wr_en_b & (wr_addr_a == wr_addr_b);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
      conflict_q <= 1'b0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= regs_d[i];
      conflict_q <= conflict_d;
    end
  end
  // forwarding priority mirrors write priority: B over A over storage
  always_comb begin
    rd_data_0 = (wr_en_b && wr_addr_b == rd_addr_0) ? wr_data_b :
                (wr_en_a && wr_addr_a == rd_addr_0) ? wr_data_a : regs_q[rd_addr_0];
    rd_data_1 = (wr_en_b && wr_addr_b == rd_addr_1) ? wr_data_b :
                (wr_en_a && wr_addr_a == rd_addr_1) ? wr_data_a : regs_q[rd_addr_1];
  end
  assign wr_conflict = conflict_q;
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed checks of writes, collisions, forwarding and async reset
module tb_register_file;
  import register_file_pkg::*;
  logic clk = 0, rst = 1;
  logic wr_en_a = 0, wr_en_b = 0;
  reg_addr_t wr_addr_a = '0, wr_addr_b = '0, rd_addr_0 = '0, rd_addr_1 = '0;
  logic [15:0] wr_data_a = '0, wr_data_b = '0, rd_data_0, rd_data_1;
  logic wr_conflict;
  int n_pass = 0, n_total = 0;
  register_file dut (
    .clk(clk), .rst(rst),
    .wr_en_a(wr_en_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
    .wr_en_b(wr_en_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
    .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1),
    .rd_data_0(rd_data_0), .rd_data_1(rd_data_1), .wr_conflict(wr_conflict)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    wr_en_a = 0;
    wr_en_b = 0;
  endtask
  initial begin
    #1;
    chk("rst_rd0", rd_data_0, 16'h0);
    chk("rst_conf", {15'b0, wr_conflict}, 16'h0);
    tick();
    rst = 0;
    wr_en_a = 1; wr_addr_a = 3'd5; wr_data_a = 16'hBEEF;
    tick();
    idle();
    rd_addr_0 = 3'd5;
    #1 chk("basic_r5", rd_data_0, 16'hBEEF);
    for (int i = 0; i < 8; i++) if (i != 5) begin
      rd_addr_1 = reg_addr_t'(i);
      #1 chk($sformatf("others_r%0d", i), rd_data_1, 16'h0);
    end
    wr_en_a = 1; wr_addr_a = 3'd1; wr_data_a = 16'h0011;
    wr_en_b = 1; wr_addr_b = 3'd2; wr_data_b = 16'h0022;
    tick();
    idle();
    rd_addr_0 = 3'd1; rd_addr_1 = 3'd2;
    #1 chk("dual_r1", rd_data_0, 16'h0011);
    chk("dual_r2", rd_data_1, 16'h0022);
    chk("dual_conf", {15'b0, wr_conflict}, 16'h0);
    wr_en_a = 1; wr_addr_a = 3'd4; wr_data_a = 16'hAAAA;
    wr_en_b = 1; wr_addr_b = 3'd4; wr_data_b = 16'h5555;
    tick();
    idle();
    rd_addr_0 = 3'd4;
    #1 chk("coll_r4", rd_data_0, 16'h5555);
    chk("coll_conf1", {15'b0, wr_conflict}, 16'h1);
    tick();
    chk("coll_conf0", {15'b0, wr_conflict}, 16'h0);
    wr_en_a = 1; wr_addr_a = 3'd6; wr_data_a = 16'h0001;
    tick();
    idle();
    rd_addr_1 = 3'd6;
    #1 chk("fwd_pre", rd_data_1, 16'h0001);
    wr_en_a = 1; wr_data_a = 16'h0F0F;
    #1 chk("fwd_a", rd_data_1, 16'h0F0F);
    wr_en_b = 1; wr_addr_b = 3'd6; wr_data_b = 16'h7777;
    rd_addr_0 = 3'd6;
    #1 chk("fwd_b", rd_data_1, 16'h7777);
    chk("fwd_b_rd0", rd_data_0, 16'h7777);
    tick();
    idle();
    #1 chk("fwd_stored", rd_data_1, 16'h7777);
    wr_en_a = 0; wr_addr_a = 3'd0; wr_data_a = 16'hFFFF;
    rd_addr_0 = 3'd0;
    #1 chk("dis_fwd", rd_data_0, 16'h0);
    tick();
    chk("dis_r0", rd_data_0, 16'h0);
    wr_en_a = 1; wr_addr_a = 3'd3; wr_data_a = 16'h0BAD;
    wr_en_b = 1; wr_addr_b = 3'd3; wr_data_b = 16'h1234;
    tick();
    idle();
    rd_addr_0 = 3'd3;
    #1 chk("pre_rst_r3", rd_data_0, 16'h1234);
    chk("pre_rst_conf", {15'b0, wr_conflict}, 16'h1);
    #1 rst = 1;
    #1 chk("rst_r3", rd_data_0, 16'h0);
    chk("rst_conf_mid", {15'b0, wr_conflict}, 16'h0);
    rd_addr_1 = 3'd5;
    chk("rst_r5", rd_data_1, 16'h0);
    wr_en_a = 1; wr_addr_a = 3'd3; wr_data_a = 16'h00FF;
    #1 chk("rst_fwd", rd_data_0, 16'h00FF);
    tick();
    idle();
    #1 chk("rst_discard", rd_data_0, 16'h0);
    rst = 0;
    wr_en_a = 1; wr_addr_a = 3'd7; wr_data_a = 16'hCAFE;
    tick();
    idle();
    rd_addr_1 = 3'd7;
    #1 chk("post_rst_r7", rd_data_1, 16'hCAFE);
    chk("post_rst_r3", rd_data_0, 16'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
